pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Valid/ready pipeline stage register with a one-entry skid buffer. Receiving end
//   of the stage-to-stage handshake in the in-order pipeline: it accepts a payload
//   from the upstream stage and presents it to the downstream stage one cycle later.
//   It absorbs a downstream stall without combinational ready paths and without
//   losing data. flush discards in-flight payloads on redirect.
// PARAMETERS
//   WIDTH    64   payload width in bits
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   flush      in   1      synchronous discard of all held entries
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept; registered, not a function of out_ready
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      payload on out_data is valid
//   out_ready  in   1      downstream accepts this cycle
//   out_data   out  WIDTH  payload, driven from the main register
//   out_count  out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//   - Storage: main register (main_q, drives out_data) and skid register (skid_q).
//   - in_acc = in_valid & in_ready. out_acc = out_valid & out_ready.
//   - Reset: state EMPTY. out_valid=0, in_ready=1, out_count=0, main_q=0, skid_q=0.
//   - States (out_valid, in_ready, out_count):
//       EMPTY (0,1,0), BUSY (1,1,1), FULL (1,0,2).
//   - EMPTY: in_acc -> BUSY, main_q<=in_data; else stay.
//   - BUSY: in_acc&out_acc -> BUSY, main_q<=in_data.
//           in_acc only -> FULL, skid_q<=in_data.
//           out_acc only -> EMPTY. Neither -> stay.
//   - FULL: in_ready=0, so in_valid is ignored. out_acc -> BUSY, main_q<=skid_q.
//           Else stay.
//   - Latency: payload accepted at edge N is visible on out_data with out_valid=1
//     after edge N. There is no combinational in->out path.
//   - Order: strict FIFO. The skid entry always follows the main entry.
//   - Stability: while out_valid=1 and out_ready=0, out_data does not change.
//   - flush=1: next state EMPTY regardless of other inputs. A payload offered that
//     cycle is dropped. main_q/skid_q keep their values, which are don't-care once
//     invalid. Priority: reset > flush > handshake.
//   - Reset asserted mid-operation: held entries are lost, outputs are at reset
//     values after the next edge.
//   - out_ready while out_valid=0 has no effect. in_data is don't-care while
//     in_valid=0.
//   - Full throughput: with out_ready held 1, one payload per cycle passes.
//     FULL is reached only under stall.
// TESTING
//   1 Reset: reset=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1,
//     out_count=0, out_data=0.
//   2 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data
//     0x11,0x22,0x33 on the next 3 cycles. in_ready stays 1, out_count stays 1.
//   3 Stall/skid: out_ready=0, push 0xA1 then 0xA2 -> out_count=2, in_ready=0,
//     out_data=0xA1. A held 0xA3 is not taken. Raise out_ready -> 0xA1, 0xA2, 0xA3
//     in order, with no loss and no duplicate.
//   4 Simultaneous: in BUSY holding 0x5, push 0x6 with out_ready=1 -> 0x5 consumed,
//     out_data=0x6, out_count=1.
//   5 Flush: in FULL (0xB1, 0xB2), flush=1 with in_valid=1, in_data=0xB3 ->
//     next cycle out_valid=0, out_count=0, in_ready=1. 0xB1/0xB2/0xB3 never appear.
//   6 Random: random in_valid/out_ready for 10k cycles against a queue model ->
//     order matches, out_count<=2, out_data stable under stall.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Valid/ready stage register with a one-entry skid buffer; ready is
//            registered so a downstream stall never reaches upstream in-cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_acc;
  logic             w_out_acc;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs decode the state register only, so in_ready has no
  // combinational dependence on out_ready.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    out_valid        = 1'b0;
    in_ready         = 1'b1;
    out_count        = 2'd0;
    case (r_state)
      EMPTY: begin
        if (w_in_acc) begin
          w_state_nxt = BUSY;
          w_load_main = 1'b1;
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        out_count = 2'd1;
        if (w_in_acc && w_out_acc) begin
          w_load_main = 1'b1;
        end else if (w_in_acc) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_out_acc) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        out_count = 2'd2;
        if (w_out_acc) begin
          w_state_nxt      = BUSY;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    // Flush overrides the handshake; payload registers simply stop loading.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : in_data;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  assign out_data = r_main;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Scoreboard bench for pipe_skid_reg: directed scenarios plus a
//            random phase checked against a FIFO reference queue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] sb_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs against the reference queue mid-cycle, then
  // advances the queue using the inputs that will be seen at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_count", W'(out_count), W'(sb_q.size()));
      check("mon_valid", W'(out_valid), W'(sb_q.size() > 0));
      check("mon_ready", W'(in_ready), W'(sb_q.size() < 2));
      if (sb_q.size() > 0) begin
        check("mon_data", out_data, sb_q[0]);
      end
      if (prev_stall && out_valid) begin
        check("mon_stable", out_data, prev_data);
      end
    end
    prev_stall = out_valid && !out_ready && !reset && !flush;
    prev_data  = out_data;
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      logic ready_m;
      ready_m = (sb_q.size() < 2);
      if (sb_q.size() > 0 && out_ready) begin
        void'(sb_q.pop_front());
      end
      if (in_valid && ready_m) begin
        sb_q.push_back(in_data);
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", W'(out_valid), '0);
    check("rst_ready", W'(in_ready), W'(1));
    check("rst_count", W'(out_count), '0);
    check("rst_data", out_data, '0);
    reset = 1'b0;

    // Streaming at full throughput
    step(1, 64'h11, 1, 0);
    check("str_d0", out_data, 64'h11);
    step(1, 64'h22, 1, 0);
    check("str_d1", out_data, 64'h22);
    check("str_cnt", W'(out_count), W'(1));
    step(1, 64'h33, 1, 0);
    check("str_d2", out_data, 64'h33);
    check("str_rdy", W'(in_ready), W'(1));
    step(0, 64'h0, 1, 0);
    check("str_empty", W'(out_valid), '0);

    // Stall fills the skid; held A3 must wait
    step(1, 64'hA1, 0, 0);
    step(1, 64'hA2, 0, 0);
    check("stl_cnt", W'(out_count), W'(2));
    check("stl_rdy", W'(in_ready), '0);
    check("stl_data", out_data, 64'hA1);
    step(1, 64'hA3, 0, 0);
    check("stl_hold", out_data, 64'hA1);
    step(1, 64'hA3, 1, 0);
    check("skid_d1", out_data, 64'hA2);
    check("skid_c1", W'(out_count), W'(1));
    step(1, 64'hA3, 1, 0);
    check("skid_d2", out_data, 64'hA3);
    step(0, 64'h0, 1, 0);
    check("skid_drained", W'(out_count), '0);

    // Simultaneous push and pop in BUSY
    step(1, 64'h5, 0, 0);
    step(1, 64'h6, 1, 0);
    check("sim_data", out_data, 64'h6);
    check("sim_cnt", W'(out_count), W'(1));
    step(0, 64'h0, 1, 0);

    // Flush from FULL drops everything including the offered payload
    step(1, 64'hB1, 0, 0);
    step(1, 64'hB2, 0, 0);
    check("fl_full", W'(out_count), W'(2));
    step(1, 64'hB3, 0, 1);
    check("fl_valid", W'(out_valid), '0);
    check("fl_cnt", W'(out_count), '0);
    check("fl_rdy", W'(in_ready), W'(1));
    step(0, 64'h0, 1, 0);
    check("fl_stay", W'(out_valid), '0);

    // Random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1) | (i[6])),
           1'($urandom_range(0, 63) == 0));
    end

    // Reset mid-operation
    step(1, 64'hC1, 0, 0);
    step(1, 64'hC2, 0, 0);
    reset = 1'b1;
    step(1, 64'hC3, 1, 0);
    check("mrst_cnt", W'(out_count), '0);
    check("mrst_data", out_data, '0);
    reset = 1'b0;
    step(0, 64'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
